// File: rtl/vend_sequencer.sv
// Multi-slot vending sequencer: coin credit, product selection, motor dispense
// handshake with timeout, and unit-by-unit change return.
module vend_sequencer #(
  parameter int NUM_SLOTS    = 4,
  parameter int PRICE        = 3,
  parameter int MAX_CREDIT   = 7,
  parameter int STOCK_INIT   = 3,
  parameter int DISP_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_1,
  input  logic                 coin_2,
  input  logic [NUM_SLOTS-1:0] sel,
  input  logic                 cancel,
  output logic [NUM_SLOTS-1:0] motor_req,
  input  logic                 motor_done,
  output logic                 change_pulse,
  input  logic                 change_ack,
  output logic                 coin_reject,
  output logic                 deny,
  output logic [2:0]           credit,
  output logic [NUM_SLOTS-1:0] sold_out,
  output logic                 busy,
  output logic                 fault
);

  localparam int TW = (DISP_TIMEOUT < 2) ? 1 : $clog2(DISP_TIMEOUT + 1);
  localparam logic [3:0]           MAX_C    = 4'(MAX_CREDIT);
  localparam logic [2:0]           PRICE_C  = 3'(PRICE);
  localparam logic [1:0]           STOCK_C  = 2'(STOCK_INIT);
  localparam logic [TW-1:0]        TLAST_C  = TW'(DISP_TIMEOUT - 1);
  localparam logic [TW-1:0]        TONE_C   = TW'(1);
  localparam logic [NUM_SLOTS-1:0] SONE_C   = NUM_SLOTS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [NUM_SLOTS-1:0] v);
    return (v != '0) && ((v & (v - SONE_C)) == '0);
  endfunction

  state_t               state_r, state_nxt_s;
  logic [2:0]           credit_r, credit_nxt_s;
  logic [1:0]           stock_r     [NUM_SLOTS];
  logic [1:0]           stock_nxt_s [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] sold_r, sold_nxt_s;
  logic [NUM_SLOTS-1:0] motor_r, motor_nxt_s;
  logic                 chg_r, chg_nxt_s;
  logic                 rej_r, rej_nxt_s;
  logic                 deny_r, deny_nxt_s;
  logic                 fault_r, fault_nxt_s;
  logic                 busy_r;
  logic [TW-1:0]        tcnt_r, tcnt_nxt_s;
  logic [3:0]           add1_s, add2_s;
  logic                 sel_empty_s;

  assign motor_req    = motor_r;
  assign change_pulse = chg_r;
  assign coin_reject  = rej_r;
  assign deny         = deny_r;
  assign credit       = credit_r;
  assign sold_out     = sold_r;
  assign busy         = busy_r;
  assign fault        = fault_r;

  assign add1_s = {1'b0, credit_r} + 4'd1;
  assign add2_s = {1'b0, credit_r} + 4'd2;

  // Stock status of the slot currently being selected
  always_comb begin
    sel_empty_s = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sel_empty_s = sel_empty_s | (sel[i] & (stock_r[i] == 2'd0));
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s  = state_r;
    credit_nxt_s = credit_r;
    stock_nxt_s  = stock_r;
    motor_nxt_s  = motor_r;
    chg_nxt_s    = chg_r;
    rej_nxt_s    = 1'b0;
    deny_nxt_s   = 1'b0;
    fault_nxt_s  = fault_r;
    tcnt_nxt_s   = tcnt_r;

    case (state_r)
      IDLE: begin
        motor_nxt_s = '0;
        chg_nxt_s   = 1'b0;
        tcnt_nxt_s  = '0;
        if (coin_1 || coin_2) begin
          // The 2-unit coin has priority; a simultaneous 1-unit coin is always refused
          if (coin_2) begin
            if (add2_s <= MAX_C) begin
              credit_nxt_s = add2_s[2:0];
              rej_nxt_s    = coin_1;
            end else begin
              rej_nxt_s = 1'b1;
            end
          end else begin
            if (add1_s <= MAX_C) begin
              credit_nxt_s = add1_s[2:0];
            end else begin
              rej_nxt_s = 1'b1;
            end
          end
        end else if (cancel) begin
          if (credit_r != 3'd0) begin
            state_nxt_s = CHANGE;
            chg_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (is_onehot(sel)) begin
          if ((credit_r < PRICE_C) || sel_empty_s) begin
            deny_nxt_s = 1'b1;
          end else begin
            motor_nxt_s = sel;
            state_nxt_s = VEND;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      VEND: begin
        rej_nxt_s = coin_1 | coin_2;
        if (motor_done) begin
          motor_nxt_s  = '0;
          tcnt_nxt_s   = '0;
          credit_nxt_s = credit_r - PRICE_C;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (motor_r[i] && (stock_r[i] != 2'd0)) begin
              stock_nxt_s[i] = stock_r[i] - 2'd1;
            end else begin
              stock_nxt_s[i] = stock_r[i];
            end
          end
          if (credit_r > PRICE_C) begin
            state_nxt_s = CHANGE;
            chg_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (tcnt_r == TLAST_C) begin
          // Motor never answered: abandon the sale and refund everything
          motor_nxt_s = '0;
          tcnt_nxt_s  = '0;
          fault_nxt_s = 1'b1;
          if (credit_r != 3'd0) begin
            state_nxt_s = CHANGE;
            chg_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          tcnt_nxt_s = tcnt_r + TONE_C;
        end
      end

      CHANGE: begin
        rej_nxt_s = coin_1 | coin_2;
        if (credit_r == 3'd0) begin
          chg_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end else if (chg_r) begin
          if (change_ack) begin
            credit_nxt_s = credit_r - 3'd1;
            chg_nxt_s    = 1'b0;
            if (credit_r == 3'd1) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = CHANGE;
            end
          end else begin
            chg_nxt_s = 1'b1;
          end
        end else begin
          chg_nxt_s = 1'b1;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        motor_nxt_s = '0;
        chg_nxt_s   = 1'b0;
        tcnt_nxt_s  = '0;
      end
    endcase
  end

  // Sold-out flags follow the stock that will be registered
  always_comb begin
    sold_nxt_s = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sold_nxt_s[i] = (stock_nxt_s[i] == 2'd0);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      credit_r <= 3'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stock_r[i] <= STOCK_C;
      end
      sold_r   <= {NUM_SLOTS{STOCK_C == 2'd0}};
      motor_r  <= '0;
      chg_r    <= 1'b0;
      rej_r    <= 1'b0;
      deny_r   <= 1'b0;
      fault_r  <= 1'b0;
      busy_r   <= 1'b0;
      tcnt_r   <= '0;
    end else begin
      state_r  <= state_nxt_s;
      credit_r <= credit_nxt_s;
      stock_r  <= stock_nxt_s;
      sold_r   <= sold_nxt_s;
      motor_r  <= motor_nxt_s;
      chg_r    <= chg_nxt_s;
      rej_r    <= rej_nxt_s;
      deny_r   <= deny_nxt_s;
      fault_r  <= fault_nxt_s;
      busy_r   <= (state_nxt_s != IDLE);
      tcnt_r   <= tcnt_nxt_s;
    end
  end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Multi-slot vending controller that sequences the coin credit register, product selection, dispense motor handshake and unit-by-unit change return.
- Sits downstream of the coin/button debounce and edge-detect logic.
- Drives one motor request per product slot and a single change-hopper handshake.
- Replaces the fixed single-product state machine with price, stock, cancel and fault handling.

Parameters:
- NUM_SLOTS, 4, number of product slots.
- PRICE, 3, price of every product in credit units (1..MAX_CREDIT).
- MAX_CREDIT, 7, maximum credit held. Credit register width is 3 bits.
- STOCK_INIT, 3, items per slot after reset. Per-slot stock counters are 2 bits wide.
- DISP_TIMEOUT, 255, cycles allowed between motor_req rising and motor_done.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- coin_1  in  1  single-cycle pulse: 1-unit coin inserted (already debounced/edge-detected)
- coin_2  in  1  single-cycle pulse: 2-unit coin inserted
- sel  in  NUM_SLOTS  single-cycle select pulse, one-hot slot index
- cancel  in  1  single-cycle pulse: refund current credit
- motor_req  out  NUM_SLOTS  one-hot dispense request, held until done
- motor_done  in  1  motor finished; sampled only while motor_req is nonzero
- change_pulse  out  1  request hopper to eject one unit, held until ack
- change_ack  in  1  hopper ejected one unit
- coin_reject  out  1  one-cycle pulse: a coin was not credited
- deny  out  1  one-cycle pulse: a selection was refused
- credit  out  3  current credit
- sold_out  out  NUM_SLOTS  bit i = stock[i]==0
- busy  out  1  state != IDLE
- fault  out  1  sticky dispense-timeout flag

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, credit=0.
  - All stock=STOCK_INIT.
  - motor_req=0, change_pulse=0, coin_reject=0, deny=0, fault=0.
  - Timeout counter=0.
- All outputs are registered.
- States: IDLE, VEND, CHANGE.
- IDLE, evaluated in this priority order:
  - Coin:
    - If coin_2 and coin_1 arrive together, coin_2 is credited and coin_1 is rejected.
    - If credit+value > MAX_CREDIT, the coin is not credited and coin_reject pulses.
    - On any coin cycle, sel and cancel are ignored (no deny).
  - cancel:
    - With credit>0, go to CHANGE.
    - With credit==0, no action.
    - cancel wins over sel in the same cycle.
  - sel:
    - Not one-hot: ignored, no deny.
    - credit<PRICE or stock[i]==0: deny pulses next cycle, stay in IDLE.
    - Otherwise latch slot i and go to VEND. motor_req[i]=1 from the next cycle (1-cycle latency).
- VEND:
  - Coins, sel and cancel are ignored; coins are rejected with coin_reject.
  - motor_req[i] is held, and the timeout counter increments each cycle.
  - On motor_done:
    - motor_req clears the next cycle.
    - stock[i] decrements and credit decrements by PRICE.
    - Next state is CHANGE if the remaining credit is >0, otherwise IDLE.
  - Timeout: counter reaches DISP_TIMEOUT without motor_done.
    - motor_req clears and fault sets (sticky until reset).
    - Stock and credit are unchanged; go to CHANGE to refund all credit.
  - motor_done and timeout in the same cycle: done wins.
- CHANGE:
  - change_pulse is asserted while credit>0. Coins are rejected; sel and cancel are ignored.
  - On change_ack:
    - credit decrements by 1 and change_pulse drops for one cycle.
    - Re-asserts if credit is still >0; otherwise go to IDLE.
  - change_ack while change_pulse=0 is ignored.
- After fault, the block keeps operating normally; fault only signals.
- Stock never wraps: decrement is only reachable when stock>0.
- Reset mid-VEND or mid-CHANGE drops motor_req and change_pulse immediately. Credit is lost (clears to 0).

Test Plan:
- reset; coin_2, coin_1 (credit=3); sel=0001; motor_done after 5 cycles -> motor_req=0001 one cycle after sel; credit=0; stock[0]=2; IDLE; change_pulse never asserted.
- credit=0; coin_2 ×3, coin_1 ×1 -> credit 2,4,6,7; then coin_2 -> coin_reject pulse, credit stays 7. sel=0010, motor_done -> credit=4; 4 change_pulse/change_ack cycles; credit=0; IDLE.
- credit=2; sel=0100 -> deny one pulse, state IDLE, credit=2. Then cancel -> two change units returned, credit=0.
- Vend slot 3 three times (credit 3 each) -> sold_out=1000. Fourth attempt with credit 3 -> deny; cancel refunds 3.
- credit=5; sel=0001; motor_done withheld -> motor_req drops after exactly DISP_TIMEOUT cycles; fault=1; stock[0] unchanged; 5 units refunded; fault stays 1 after the next successful vend.
- Simultaneous coin_1+coin_2 at credit=6 -> coin_2 rejected (overflow) and coin_1 rejected (lower priority); both produce a single coin_reject pulse; credit=6. Reset asserted mid-CHANGE -> change_pulse=0, credit=0 immediately.
